// File: rtl/motor_pkg.sv
// motor_pkg: shared definitions for the motor move controller.
// Holds the controller FSM state encoding, default timing parameters,
// the 16-bit position/step widths and the position update helper.
package motor_pkg;

   localparam int unsigned STEP_W = 16;
   localparam int unsigned POS_W  = 16;

   localparam int unsigned SETUP_CYC_DEF  = 4;
   localparam int unsigned PERIOD_MIN_DEF = 2;

   localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
   localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
   localparam logic [POS_W-1:0]  POS_ZERO  = {POS_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2,
      ST_DONE   = 2'd3
   } motor_state_t;

   // Position advance for one step: 2 half-steps in full-step mode, 1 otherwise.
   // Wraps in two's complement; no saturation.
   function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos,
                                                 input logic             dir,
                                                 input logic             full);
      logic [POS_W-1:0] delta;
      delta = {{(POS_W-2){1'b0}}, full, ~full};
      if (dir) begin
         return pos + delta;
      end else begin
         return pos - delta;
      end
   endfunction

endpackage

// File: rtl/motor_move_ctrl_if.sv
// motor_move_ctrl_if: command handshake and motor sequencer signals.
//   cmd_valid/cmd_ready/cmd_steps/cmd_dir/cmd_full/cmd_period : move command
//   abort                                                       : stop current move
//   step_en/direction/step_mode                                 : phase sequencer drive
//   busy/done/aborted/position                                  : status
// master = command source, slave = controller.
interface motor_move_ctrl_if;
   import motor_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [STEP_W-1:0] cmd_steps;
   logic              cmd_dir;
   logic              cmd_full;
   logic [STEP_W-1:0] cmd_period;
   logic              abort;
   logic              step_en;
   logic              direction;
   logic              step_mode;
   logic              busy;
   logic              done;
   logic              aborted;
   logic [POS_W-1:0]  position;

   modport master (
      output cmd_valid, cmd_steps, cmd_dir, cmd_full, cmd_period, abort,
      input  cmd_ready, step_en, direction, step_mode, busy, done, aborted, position
   );

   modport slave (
      input  cmd_valid, cmd_steps, cmd_dir, cmd_full, cmd_period, abort,
      output cmd_ready, step_en, direction, step_mode, busy, done, aborted, position
   );

endinterface

// File: rtl/motor_move_ctrl_step_timer.sv
// step_timer: loadable down-counter producing the step period tick.
//   clk, nrst : clock, async active-low reset
//   load_i    : load value_i into the counter (wins over counting)
//   value_i   : reload value
//   en_i      : count down while nonzero
//   clr_i     : clear the counter (highest priority)
//   tick_o    : high while enabled and the counter holds 1, i.e. in the
//               cycle before the edge at which the owner acts on expiry
module step_timer
   import motor_pkg::*;
(
   input  logic              clk,
   input  logic              nrst,
   input  logic              load_i,
   input  logic [STEP_W-1:0] value_i,
   input  logic              en_i,
   input  logic              clr_i,
   output logic              tick_o
);

   logic [STEP_W-1:0] cnt_q;
   logic [STEP_W-1:0] cnt_d;

   // Counter next value: clear, then load, then decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = STEP_ZERO;
      end else if (load_i) begin
         cnt_d = value_i;
      end else if (en_i && (cnt_q != STEP_ZERO)) begin
         cnt_d = cnt_q - STEP_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= STEP_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == STEP_ONE);

endmodule

// File: rtl/motor_move_ctrl.sv
// motor_move_ctrl: stepper move controller.
//   clk, nrst : clock, async active-low reset
//   bus       : motor_move_ctrl_if slave port (command handshake, abort,
//               step_en/direction/step_mode to the phase sequencer,
//               busy/done/aborted/position status)
// A move is accepted in IDLE, waits SETUP_CYC cycles in SETTLE, then RUN
// issues the latched number of one-cycle step pulses spaced by the latched
// (clamped) period. DONE lasts one cycle and pulses done.
module motor_move_ctrl
   import motor_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = SETUP_CYC_DEF,
   parameter int unsigned PERIOD_MIN = PERIOD_MIN_DEF
) (
   input  logic             clk,
   input  logic             nrst,
   motor_move_ctrl_if.slave bus
);

   localparam logic [STEP_W-1:0] SETUP_VAL = STEP_W'(SETUP_CYC);
   localparam logic [STEP_W-1:0] PMIN_VAL  = STEP_W'(PERIOD_MIN);

   motor_state_t      state_q, state_d;
   logic [STEP_W-1:0] steps_left_q, steps_left_d;
   logic [STEP_W-1:0] period_q, period_d;
   logic              dir_q, dir_d;
   logic              full_q, full_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic              step_en_q, step_en_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;

   logic              accept_s;
   logic              tmr_load_s;
   logic [STEP_W-1:0] tmr_val_s;
   logic              tmr_en_s;
   logic              tmr_clr_s;
   logic              tmr_tick_s;

   assign accept_s = bus.cmd_valid && ready_q;
   assign tmr_en_s = (state_q == ST_SETTLE) || (state_q == ST_RUN);

   step_timer u_timer (
      .clk     (clk),
      .nrst    (nrst),
      .load_i  (tmr_load_s),
      .value_i (tmr_val_s),
      .en_i    (tmr_en_s),
      .clr_i   (tmr_clr_s),
      .tick_o  (tmr_tick_s)
   );

   // Next state, command latching, pulse scheduling and timer control.
   always_comb begin
      state_d      = state_q;
      steps_left_d = steps_left_q;
      period_d     = period_q;
      dir_d        = dir_q;
      full_d       = full_q;
      aborted_d    = aborted_q;
      step_en_d    = 1'b0;
      done_d       = 1'b0;
      tmr_load_s   = 1'b0;
      tmr_val_s    = period_q;
      tmr_clr_s    = 1'b0;
      // Position moves at the edge that closes each step_en cycle.
      if (step_en_q) begin
         pos_d = pos_step(pos_q, dir_q, full_q);
      end else begin
         pos_d = pos_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               steps_left_d = bus.cmd_steps;
               dir_d        = bus.cmd_dir;
               full_d       = bus.cmd_full;
               aborted_d    = 1'b0;
               if (bus.cmd_period < PMIN_VAL) begin
                  period_d = PMIN_VAL;
               end else begin
                  period_d = bus.cmd_period;
               end
               if (bus.cmd_steps == STEP_ZERO) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = ST_SETTLE;
                  tmr_load_s = 1'b1;
                  tmr_val_s  = SETUP_VAL;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE, ST_RUN: begin
            // Abort has priority over a pulse due at the same edge.
            if (bus.abort) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               aborted_d = 1'b1;
               tmr_clr_s = 1'b1;
            end else if (step_en_q && (steps_left_q == STEP_ZERO)) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               tmr_clr_s = 1'b1;
            end else if (tmr_tick_s && (steps_left_q != STEP_ZERO)) begin
               // Reloading on the pulse edge makes the next tick land exactly
               // one period after this pulse.
               state_d      = ST_RUN;
               step_en_d    = 1'b1;
               steps_left_d = steps_left_q - STEP_ONE;
               tmr_load_s   = 1'b1;
               tmr_val_s    = period_q;
            end else begin
               state_d = state_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d == ST_SETTLE) || (state_d == ST_RUN);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         steps_left_q <= STEP_ZERO;
         period_q     <= STEP_ZERO;
         dir_q        <= 1'b1;
         full_q       <= 1'b1;
         pos_q        <= POS_ZERO;
         step_en_q    <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         steps_left_q <= steps_left_d;
         period_q     <= period_d;
         dir_q        <= dir_d;
         full_q       <= full_d;
         pos_q        <= pos_d;
         step_en_q    <= step_en_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.cmd_ready = ready_q;
   assign bus.step_en   = step_en_q;
   assign bus.direction = dir_q;
   assign bus.step_mode = full_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.aborted   = aborted_q;
   assign bus.position  = pos_q;

endmodule

// File: tb/tb_motor_move_ctrl.sv
// tb_motor_move_ctrl: self-checking bench for motor_move_ctrl.
// Each move is predicted from the timing rules (pulse edges at
// accept + SETUP + k*period, done one edge after the last pulse or after an
// abort) and observed cycle by cycle on the falling clock edge.
module tb_motor_move_ctrl;

   localparam int SETUP = 4;
   localparam int PMIN  = 2;

   logic        clk = 1'b0;
   logic        nrst;
   int          cyc = 0;
   logic [15:0] pos_m;
   int          n_total = 0;
   int          n_bad = 0;

   motor_move_ctrl_if bus ();

   motor_move_ctrl #(.SETUP_CYC(SETUP), .PERIOD_MIN(PMIN)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_ready"},   bus.cmd_ready, 1'b1);
      check_val({pfx, "_step_en"}, bus.step_en,   1'b0);
      check_val({pfx, "_done"},    bus.done,      1'b0);
      check_val({pfx, "_aborted"}, bus.aborted,   1'b0);
      check_val({pfx, "_busy"},    bus.busy,      1'b0);
      check_val({pfx, "_dir"},     bus.direction, 1'b1);
      check_val({pfx, "_mode"},    bus.step_mode, 1'b1);
      check_val({pfx, "_pos"},     bus.position,  16'h0000);
   endtask

   // Issue one move at a falling edge and check it to completion.
   // ab_off < 0: no abort; otherwise abort is high in cycle accept+ab_off.
   task automatic run_move(input logic [15:0] steps, input logic [15:0] period,
                           input logic dir, input logic full,
                           input bit hold, input int ab_off);
      int   a, p, last_e, cut, exp_done, got_done, sgn;
      logic exp_ab, got_ab;
      bit   fin;
      int   exp_e[$];
      int   got_e[$];

      for (int w = 0; w < 64 && !bus.cmd_ready; w++) @(negedge clk);
      check_val("ready_wait", bus.cmd_ready, 1'b1);

      bus.cmd_steps  = steps;
      bus.cmd_period = period;
      bus.cmd_dir    = dir;
      bus.cmd_full   = full;
      bus.cmd_valid  = 1'b1;
      bus.abort      = 1'($urandom_range(0, 1));  // must be ignored in IDLE
      a = cyc + 1;

      // Reference prediction.
      p = (int'(period) < PMIN) ? PMIN : int'(period);
      exp_ab = 1'b0;
      if (steps == 16'd0) begin
         exp_done = a;
      end else begin
         last_e = a + SETUP + (int'(steps) - 1) * p;
         if (ab_off >= 0 && a + ab_off <= last_e) begin
            exp_ab   = 1'b1;
            cut      = a + ab_off;
            exp_done = cut + 1;
         end else begin
            cut      = last_e;
            exp_done = last_e + 1;
         end
         for (int k = 0; k < int'(steps); k++)
            if (a + SETUP + k * p <= cut) exp_e.push_back(a + SETUP + k * p);
      end
      sgn   = (full ? 2 : 1) * (dir ? 1 : -1);
      pos_m = pos_m + 16'(exp_e.size() * sgn);

      got_done = -1;
      got_ab   = 1'b0;
      fin      = 1'b0;
      for (int g = 0; g < 40000 && !fin; g++) begin
         @(negedge clk);
         bus.abort = (ab_off >= 0) && (cyc == a + ab_off);
         if (!hold || cyc >= exp_done) bus.cmd_valid = 1'b0;
         if (bus.step_en) got_e.push_back(cyc);
         if (bus.done) begin
            got_done = cyc;
            got_ab   = bus.aborted;
         end
         check_val("busy", bus.busy, (cyc >= a) && (cyc < exp_done));
         if (cyc == a) begin
            check_val("direction", bus.direction, dir);
            check_val("step_mode", bus.step_mode, full);
            check_val("aborted_clr", bus.aborted, 1'b0);
         end
         if (cyc == exp_done) check_val("ready_in_done", bus.cmd_ready, 1'b0);
         if (cyc >= exp_done + 1) begin
            check_val("ready_after", bus.cmd_ready, 1'b1);
            check_val("aborted_hold", bus.aborted, exp_ab);
            check_val("position", bus.position, pos_m);
            fin = 1'b1;
         end
      end
      bus.abort     = 1'b0;
      bus.cmd_valid = 1'b0;
      if (!fin) check_val("move_timeout", 32'd0, 32'd1);

      check_val("pulse_count", got_e.size(), exp_e.size());
      for (int k = 0; k < got_e.size() && k < exp_e.size(); k++)
         check_val("pulse_cyc", got_e[k], exp_e[k]);
      check_val("done_cyc", got_done, exp_done);
      check_val("done_aborted", got_ab, exp_ab);
   endtask

   initial begin
      nrst           = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_steps  = 16'd0;
      bus.cmd_dir    = 1'b0;
      bus.cmd_full   = 1'b0;
      bus.cmd_period = 16'd0;
      bus.abort      = 1'b0;
      pos_m          = 16'h0000;

      #12;
      check_reset_outputs("por");
      @(negedge clk);
      nrst = 1'b1;

      // Basic move, reverse back to 0, reverse half step, zero steps, clamp, abort.
      run_move(16'd3, 16'd10, 1'b1, 1'b1, 1'b0, -1);
      check_val("basic_pos", bus.position, 16'd6);
      run_move(16'd3, 16'd3, 1'b0, 1'b1, 1'b0, -1);
      run_move(16'd5, 16'd2, 1'b0, 1'b0, 1'b0, -1);
      check_val("rev_half_pos", bus.position, 16'hFFFB);
      run_move(16'd0, 16'd7, 1'b1, 1'b1, 1'b0, -1);
      check_val("zero_pos", bus.position, 16'hFFFB);
      run_move(16'd3, 16'd0, 1'b1, 1'b0, 1'b0, -1);
      run_move(16'd100, 16'd8, 1'b1, 1'b1, 1'b1, 27);
      check_val("abort_pos", bus.position, 16'h0004);
      check_val("abort_flag", bus.aborted, 1'b1);

      // Randomized moves, some with abort and some holding cmd_valid.
      for (int i = 0; i < 30; i++) begin
         logic [15:0] st, pr;
         int          ab;
         st = 16'($urandom_range(0, 6));
         pr = 16'($urandom_range(0, 9));
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, SETUP + 6 * 9) : -1;
         run_move(st, pr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ab);
      end

      // Reset in the middle of RUN.
      bus.cmd_steps  = 16'd50;
      bus.cmd_period = 16'd5;
      bus.cmd_dir    = 1'b0;
      bus.cmd_full   = 1'b1;
      bus.cmd_valid  = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (8) @(negedge clk);
      check_val("pre_rst_busy", bus.busy, 1'b1);
      #2 nrst = 1'b0;
      #1 check_reset_outputs("mid_rst");
      @(negedge clk);
      check_val("rst_no_done", bus.done, 1'b0);
      nrst  = 1'b1;
      pos_m = 16'h0000;
      run_move(16'd3, 16'd4, 1'b1, 1'b0, 1'b0, -1);
      check_val("post_rst_pos", bus.position, 16'd3);

      // Walk to 16'h7FFF, then one half step forward wraps to 16'h8000.
      run_move(16'd16381, 16'd2, 1'b1, 1'b1, 1'b0, -1);
      run_move(16'd2, 16'd0, 1'b1, 1'b0, 1'b0, -1);
      check_val("pos_7fff", bus.position, 16'h7FFF);
      run_move(16'd1, 16'd5, 1'b1, 1'b0, 1'b0, -1);
      check_val("pos_wrap", bus.position, 16'h8000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/motor_move_ctrl.md
MOTOR_MOVE_CTRL -- requirements
Module: motor_move_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SETUP_CYC, 4: cycles between direction/mode update and first step pulse; legal range 1..255.
- PERIOD_MIN, 2: minimum legal step period in clocks; smaller requests are clamped to this value.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: single system clock, rising edge.
- nrst, in, 1: asynchronous active-low reset.
- cmd_valid, in, 1: move command present.
- cmd_ready, out, 1: controller can accept a command.
- cmd_steps, in, 16: number of step pulses to issue.
- cmd_dir, in, 1: 1 = forward, 0 = reverse.
- cmd_full, in, 1: 1 = full step, 0 = half step.
- cmd_period, in, 16: clocks between successive step pulses.
- abort, in, 1: stop the current move.
- step_en, out, 1: one-cycle advance pulse to the motor phase sequencer.
- direction, out, 1: direction to the phase sequencer.
- step_mode, out, 1: full/half-step select to the phase sequencer.
- busy, out, 1: move in progress (SETTLE or RUN).
- done, out, 1: one-cycle pulse at the end of a move.
- aborted, out, 1: the last move ended by abort; held until the next accept.
- position, out, 16: signed position in half-step units.

Function
REQ-003 A command SHALL be accepted at a rising edge where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 1 only in IDLE.
REQ-004 On accept, the controller SHALL latch cmd_steps, cmd_dir, cmd_full, and max(cmd_period, PERIOD_MIN); direction and step_mode SHALL take the latched values from the accept edge onward and SHALL NOT change until the next accept.
REQ-005 FSM states SHALL be IDLE, SETTLE, RUN and DONE.
- IDLE->SETTLE on accept with cmd_steps!=0.
- IDLE->DONE on accept with cmd_steps==0; no pulse is issued.
- SETTLE->RUN after SETUP_CYC cycles.
- RUN->DONE after the last pulse or on abort.
- DONE->IDLE after 1 cycle.
REQ-006 With the accept edge numbered E0, the first step_en SHALL be high in the cycle following edge E(SETUP_CYC). Each later pulse SHALL follow the previous one by exactly the latched period. Every pulse SHALL last exactly one cycle.
REQ-007 The controller SHALL issue exactly cmd_steps pulses. After the cycle containing the last pulse, DONE SHALL follow with done=1 for one cycle, and cmd_ready=1 the cycle after that.
REQ-008 position SHALL update at the edge that ends each step_en cycle:
- +2 (full step) or +1 (half step) when direction=1.
- -2 or -1 when direction=0.
- Two's-complement wrap on overflow, with no saturation.
REQ-009 When abort=1 in SETTLE or RUN, the controller SHALL issue no further step_en pulses and SHALL enter DONE with aborted=1. If abort and a pulse are due in the same cycle, abort wins and no pulse is issued. In IDLE or DONE, abort SHALL be ignored.
REQ-010 cmd_valid while busy SHALL be ignored; nothing is queued.
REQ-011 busy SHALL be 1 exactly in SETTLE and RUN.

Reset
REQ-012 While nrst=0, the controller SHALL immediately force:
- state=IDLE, cmd_ready=1 (after release).
- step_en=0, done=0, aborted=0, busy=0.
- direction=1, step_mode=1, position=0.
- All counters cleared.
REQ-013 Reset mid-move SHALL discard the move with no done pulse. The first edge after release SHALL be able to accept a command.

Structure
REQ-014 The shared package motor_pkg SHALL hold the FSM state encoding, the defaults for SETUP_CYC and PERIOD_MIN, and the 16-bit position/step width constants.
REQ-015 One sub-module, step_timer, SHALL provide the loadable down-counter that produces the period tick. It SHALL take a load, a 16-bit value, an enable and an abort-clear, and output a tick. The step counter, FSM and position SHALL live in the top module.

Verification
REQ-016 Basic move: SETUP_CYC=4, steps=3, period=10, dir=1, full=1 -> step_en high in the cycles after E4, E14 and E24; done high after E25; cmd_ready=1 after E26; position=6.
REQ-017 Reverse half step: steps=5, period=2, dir=0, full=0, from position 0 -> 5 pulses spaced 2 cycles apart; position=-5 (16'hFFFB).
REQ-018 Zero and clamp:
- steps=0 -> done one cycle after accept, no step_en, position unchanged.
- period=0 -> pulses spaced PERIOD_MIN=2 apart.
REQ-019 Abort: steps=100, period=8, abort asserted in the cycle a pulse is due after 3 pulses -> exactly 3 pulses, done=1 and aborted=1 next, position=6.
REQ-020 Busy and reset:
- cmd_valid held during a move -> ignored and no second move.
- nrst pulsed low in RUN -> all outputs take reset values immediately, no done pulse, and a new command is accepted at the first edge after release.
- Wrap: position 16'h7FFF forced via moves, +1 half step -> 16'h8000.
